// File: rtl/router_pkt_tx_if.sv
// Signal bundle between router_pkt_tx, its host (payload push / start) and the router write port.
interface router_pkt_tx_if #(
  parameter int unsigned DEPTH = 64
);
  logic                    ld_valid;
  logic [7:0]              ld_data;
  logic                    ld_ready;
  logic                    start;
  logic [1:0]              dest;
  logic [5:0]              len;
  logic                    start_err;
  logic                    idle;
  logic [7:0]              data_in;
  logic                    pkt_valid;
  logic                    busy;
  logic                    error;
  logic                    done;
  logic                    pkt_err;
  logic [$clog2(DEPTH):0]  fifo_cnt;

  modport master (
    input  ld_valid, ld_data, start, dest, len, busy, error,
    output ld_ready, start_err, idle, data_in, pkt_valid, done, pkt_err, fifo_cnt
  );

  modport slave (
    output ld_valid, ld_data, start, dest, len, busy, error,
    input  ld_ready, start_err, idle, data_in, pkt_valid, done, pkt_err, fifo_cnt
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers host payload bytes in a FIFO and emits header, payload, parity,
// then watches the router error line for ERR_WAIT cycles.
module router_pkt_tx #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ERR_WAIT = 3
) (
  input logic             clock,
  input logic             rst,
  router_pkt_tx_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StParity, StErrw} state_e;
  state_e state_q, state_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   cnt_q, cnt_d;
  logic [5:0]    rem_q, rem_d;
  logic [7:0]    parity_q, parity_d;
  logic [EW-1:0] ew_cnt_q, ew_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ready_q, idle_q, done_q, done_d;
  logic          start_err_q, start_err_d, pkt_err_q, pkt_err_d;
  logic          xfer, push, pop, start_bad, last_ew;

  assign xfer      = !bus.busy && (state_q inside {StHeader, StPayload, StParity});
  assign push      = bus.ld_valid && ready_q;
  assign pop       = xfer && (state_q == StPayload);
  assign rd_next   = rd_ptr_q + AW'(1);
  assign start_bad = (bus.len == 6'd0) || (bus.dest == 2'd3) || ((AW+1)'(bus.len) > cnt_q);
  assign last_ew   = (ew_cnt_q == EW'(ERR_WAIT - 1));
  assign cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.start && !start_bad) state_d = StHeader;
      StHeader:  if (xfer) state_d = StPayload;
      StPayload: if (xfer && rem_q == 6'd1) state_d = StParity;
      StParity:  if (xfer) state_d = StErrw;
      StErrw:    if (last_ew) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Payload byte k+1 is looked ahead from the FIFO so it can be presented the cycle after byte k
  // transfers, while the pop itself still lines up with the transfer of byte k.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    pkt_err_d   = pkt_err_q;
    parity_d    = parity_q;
    rem_d       = rem_q;
    ew_cnt_d    = ew_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (start_bad) begin
            start_err_d = 1'b1;
          end else begin
            data_d    = {bus.len, bus.dest};
            parity_d  = {bus.len, bus.dest};
            valid_d   = 1'b1;
            rem_d     = bus.len;
            pkt_err_d = 1'b0;
          end
        end
      end
      StHeader: if (xfer) data_d = mem[rd_ptr_q];
      StPayload: begin
        if (xfer) begin
          parity_d = parity_q ^ data_q;
          rem_d    = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            data_d  = parity_q ^ data_q;
            valid_d = 1'b0;
          end else begin
            data_d = mem[rd_next];
          end
        end
      end
      StParity: begin
        if (xfer) begin
          ew_cnt_d = '0;
          done_d   = (ERR_WAIT == 1);
        end
      end
      StErrw: begin
        if (bus.error) pkt_err_d = 1'b1;
        if (!last_ew) begin
          ew_cnt_d = ew_cnt_q + EW'(1);
          done_d   = (ew_cnt_q == EW'(ERR_WAIT - 2));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      parity_q    <= '0;
      ew_cnt_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      idle_q      <= 1'b1;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      parity_q    <= parity_d;
      ew_cnt_q    <= ew_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ready_q     <= (cnt_d != (AW+1)'(DEPTH));
      idle_q      <= (state_d == StIdle);
      done_q      <= done_d;
      start_err_q <= start_err_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= bus.ld_data;
  end

  assign bus.data_in   = data_q;
  assign bus.pkt_valid = valid_q;
  assign bus.ld_ready  = ready_q;
  assign bus.idle      = idle_q;
  assign bus.done      = done_q;
  assign bus.start_err = start_err_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.fifo_cnt  = cnt_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: packet framing, busy stalls, rejects, error capture, FIFO
// full behaviour and asynchronous reset mid-packet.
module tb_router_pkt_tx;
  logic clock = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  router_pkt_tx_if #(.DEPTH(64)) bus ();

  router_pkt_tx #(.DEPTH(64), .ERR_WAIT(3)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [1:0] d, input logic [5:0] l);
    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.start = 1'b0; bus.dest = '0; bus.len = '0;
    bus.busy = 1'b0; bus.error = 1'b0;
    #2;
    checks++;
    if ({bus.data_in, bus.pkt_valid, bus.ld_ready, bus.idle, bus.done, bus.start_err,
         bus.pkt_err, bus.fifo_cnt} !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset_values got data=%h v=%b rdy=%b idle=%b done=%b serr=%b perr=%b cnt=%0d",
               bus.data_in, bus.pkt_valid, bus.ld_ready, bus.idle, bus.done, bus.start_err,
               bus.pkt_err, bus.fifo_cnt);
    end
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [6] = '{8'h11, 8'h04, 8'h11, 8'h22, 8'h33, 8'h15};
    push(8'h04); push(8'h11); push(8'h22); push(8'h33);
    checks++;
    if (bus.fifo_cnt !== 7'd4) begin
      errors++; $display("FAIL basic_cnt got %0d want 4", bus.fifo_cnt);
    end
    start_pkt(2'd1, 6'd4);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.data_in !== exp[i] || bus.pkt_valid !== (i < 5)) begin
        errors++;
        $display("FAIL basic_byte[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                 exp[i], i < 5);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.done !== (i == 2)) begin
        errors++; $display("FAIL basic_done[%0d] got %b want %b", i, bus.done, i == 2);
      end
      tick();
    end
    checks++;
    if ({bus.idle, bus.done, bus.pkt_err, bus.fifo_cnt} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL basic_end got idle=%b done=%b perr=%b cnt=%0d want 1 0 0 0",
               bus.idle, bus.done, bus.pkt_err, bus.fifo_cnt);
    end
  endtask

  task automatic test_busy();
    logic [7:0] exp [9] = '{8'h11, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h15};
    push(8'h04); push(8'h11); push(8'h22); push(8'h33);
    start_pkt(2'd1, 6'd4);
    for (int i = 0; i < 12; i++) begin
      bus.busy = (i >= 2 && i <= 4);
      checks++;
      if (i < 9) begin
        if (bus.data_in !== exp[i] || bus.pkt_valid !== (i < 8)) begin
          errors++;
          $display("FAIL busy_byte[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                   exp[i], i < 8);
        end
      end else if (bus.done !== (i == 11)) begin
        errors++; $display("FAIL busy_done[%0d] got %b want %b", i, bus.done, i == 11);
      end
      tick();
    end
    bus.busy = 1'b0;
    checks++;
    if (bus.idle !== 1'b1) begin
      errors++; $display("FAIL busy_idle got %b want 1", bus.idle);
    end
  endtask

  task automatic test_reject();
    push(8'h5A); push(8'hA5);
    start_pkt(2'd0, 6'd5);
    checks++;
    if ({bus.start_err, bus.idle, bus.pkt_valid} !== 3'b110) begin
      errors++; $display("FAIL reject_len got serr/idle/v=%b%b%b want 110", bus.start_err,
                         bus.idle, bus.pkt_valid);
    end
    tick();
    checks++;
    if ({bus.start_err, bus.idle, bus.pkt_valid} !== 3'b010) begin
      errors++; $display("FAIL reject_pulse got serr/idle/v=%b%b%b want 010", bus.start_err,
                         bus.idle, bus.pkt_valid);
    end
    start_pkt(2'd3, 6'd1);
    checks++;
    if (bus.start_err !== 1'b1) begin
      errors++; $display("FAIL reject_dest got %b want 1", bus.start_err);
    end
    tick();
    start_pkt(2'd1, 6'd0);
    checks++;
    if (bus.start_err !== 1'b1) begin
      errors++; $display("FAIL reject_len0 got %b want 1", bus.start_err);
    end
    tick();
    checks++;
    if (bus.idle !== 1'b1 || bus.pkt_valid !== 1'b0 || bus.fifo_cnt !== 7'd2) begin
      errors++; $display("FAIL reject_state got idle=%b v=%b cnt=%0d want 1 0 2", bus.idle,
                         bus.pkt_valid, bus.fifo_cnt);
    end
  endtask

  task automatic test_error();
    logic [7:0] exp [4] = '{8'h0A, 8'h5A, 8'hA5, 8'hF5};
    start_pkt(2'd2, 6'd2);
    for (int i = 0; i < 7; i++) begin
      bus.error = (i == 5);
      checks++;
      if (i < 4) begin
        if (bus.data_in !== exp[i] || bus.pkt_valid !== (i < 3)) begin
          errors++;
          $display("FAIL error_byte[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                   exp[i], i < 3);
        end
      end else if (bus.done !== (i == 6) || (i == 6 && bus.pkt_err !== 1'b1)) begin
        errors++; $display("FAIL error_done[%0d] got done=%b perr=%b", i, bus.done, bus.pkt_err);
      end
      tick();
    end
    bus.error = 1'b0;
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.idle !== 1'b1) begin
      errors++; $display("FAIL error_hold got perr=%b idle=%b want 1 1", bus.pkt_err, bus.idle);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    logic [7:0] tail [4] = '{8'h09, 8'h3F, 8'hC0, 8'hF6};
    bus.ld_valid = 1'b1;
    for (int v = 0; v < 65; v++) begin
      bus.ld_data = 8'(v);
      tick();
      if (v == 62 || v == 63) begin
        checks++;
        if (bus.ld_ready !== (v == 62) || bus.fifo_cnt !== 7'(v + 1)) begin
          errors++; $display("FAIL full_fill[%0d] got rdy=%b cnt=%0d want %b %0d", v,
                             bus.ld_ready, bus.fifo_cnt, v == 62, v + 1);
        end
      end
    end
    bus.ld_valid = 1'b0;
    checks++;
    if (bus.fifo_cnt !== 7'd64 || bus.pkt_err !== 1'b1) begin
      errors++; $display("FAIL full_drop got cnt=%0d perr=%b want 64 1", bus.fifo_cnt,
                         bus.pkt_err);
    end
    // Long packet with the host pushing 0xC0 every cycle throughout.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hC0;
    start_pkt(2'd0, 6'd63);
    checks++;
    if (bus.pkt_err !== 1'b0) begin
      errors++; $display("FAIL full_perr_clear got %b want 0", bus.pkt_err);
    end
    for (int i = 0; i < 68; i++) begin
      exp = (i == 0) ? 8'hFC : (i == 64) ? 8'hC3 : 8'(i - 1);
      checks++;
      if (i < 65) begin
        if (bus.data_in !== exp || bus.pkt_valid !== (i < 64)) begin
          errors++;
          $display("FAIL full_byte[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                   exp, i < 64);
        end
      end else if (bus.done !== (i == 67)) begin
        errors++; $display("FAIL full_done[%0d] got %b want %b", i, bus.done, i == 67);
      end
      tick();
    end
    bus.ld_valid = 1'b0;
    checks++;
    if (bus.fifo_cnt !== 7'd64 || bus.ld_ready !== 1'b0 || bus.idle !== 1'b1) begin
      errors++; $display("FAIL full_after got cnt=%0d rdy=%b idle=%b want 64 0 1", bus.fifo_cnt,
                         bus.ld_ready, bus.idle);
    end
    start_pkt(2'd1, 6'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.data_in !== tail[i] || bus.pkt_valid !== (i < 3)) begin
        errors++;
        $display("FAIL full_tail[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                 tail[i], i < 3);
      end
      tick();
    end
    tick(); tick(); tick();
    checks++;
    if (bus.idle !== 1'b1 || bus.fifo_cnt !== 7'd62) begin
      errors++; $display("FAIL full_tail_end got idle=%b cnt=%0d want 1 62", bus.idle,
                         bus.fifo_cnt);
    end
  endtask

  task automatic test_midreset();
    logic [7:0] exp  [3] = '{8'h16, 8'hC0, 8'hC0};
    logic [7:0] clean [5] = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h0C};
    start_pkt(2'd2, 6'd5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.data_in !== exp[i] || bus.pkt_valid !== 1'b1) begin
        errors++; $display("FAIL mid_byte[%0d] got %h/%b want %h/1", i, bus.data_in,
                           bus.pkt_valid, exp[i]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.pkt_valid, bus.fifo_cnt, bus.idle, bus.data_in} !== {1'b0, 7'd0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL mid_async got v=%b cnt=%0d idle=%b data=%h want 0 0 1 00",
                         bus.pkt_valid, bus.fifo_cnt, bus.idle, bus.data_in);
    end
    #2 rst = 1'b0;
    tick();
    push(8'h01); push(8'h02); push(8'h03);
    start_pkt(2'd0, 6'd3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i < 5) begin
        if (bus.data_in !== clean[i] || bus.pkt_valid !== (i < 4)) begin
          errors++;
          $display("FAIL clean_byte[%0d] got %h/%b want %h/%b", i, bus.data_in, bus.pkt_valid,
                   clean[i], i < 4);
        end
      end else if (bus.done !== (i == 7) || bus.pkt_err !== 1'b0) begin
        errors++; $display("FAIL clean_done[%0d] got done=%b perr=%b", i, bus.done, bus.pkt_err);
      end
      tick();
    end
    checks++;
    if (bus.idle !== 1'b1 || bus.fifo_cnt !== 7'd0) begin
      errors++; $display("FAIL clean_end got idle=%b cnt=%0d want 1 0", bus.idle, bus.fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_reject();
    test_error();
    test_full();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
